// File: rtl/reg_dump_ctrl_if.sv
// Purpose : bundles the register-file read port (A1) and the dump output beat stream.
// Ports   : rf_sel/rf_addr/rf_rdata (read port 1), out_valid/out_ready/out_idx/out_data/out_last (beat stream).
// master = the dump controller, slave = register file plus beat consumer.
interface reg_dump_ctrl_if;
    logic        rf_sel;
    logic [4:0]  rf_addr;
    logic [63:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [63:0] out_data;
    logic        out_last;

    modport master (
        output rf_sel, rf_addr, out_valid, out_idx, out_data, out_last,
        input  rf_rdata, out_ready
    );

    modport slave (
        input  rf_sel, rf_addr, out_valid, out_idx, out_data, out_last,
        output rf_rdata, out_ready
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// Purpose : walks register indices FIRST_IDX..LAST_IDX through rs1 read port and emits one beat per register.
// Latency : start at edge N -> READ at N+1 -> beat valid at N+2 (halted=1); one beat per 2 cycles at best.
// Backpressure : a beat is held stable until out_ready; a low 'halted' pauses the read without losing the index.
// Ports   : clk, rst (sync, active-high), start, abort, halted, busy, done, bus (reg_dump_ctrl_if.master).
module reg_dump_ctrl #(
    parameter int FIRST_IDX = 1,
    parameter int LAST_IDX  = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            halted,
    output logic            busy,
    output logic            done,
    reg_dump_ctrl_if.master bus
);

    localparam logic [4:0] FIRST_L = 5'(FIRST_IDX);
    localparam logic [4:0] LAST_L  = 5'(LAST_IDX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  idx;
    logic        out_valid_q;
    logic        out_last_q;
    logic [4:0]  out_idx_q;
    logic [63:0] out_data_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort dominates every other input
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start)         state_nxt = READ;
                READ: if (halted)        state_nxt = OUT;
                OUT:  if (bus.out_ready) state_nxt = out_last_q ? DONE : READ;
                DONE:                    state_nxt = IDLE;
                default:                 state_nxt = IDLE;
            endcase
        end
    end

    // Outputs; the read port is only claimed while the core is actually halted
    always_comb begin
        bus.rf_sel    = (state == READ) && halted;
        bus.rf_addr   = (state == READ) ? idx : 5'd0;
        bus.out_valid = out_valid_q;
        bus.out_idx   = out_idx_q;
        bus.out_data  = out_data_q;
        bus.out_last  = out_last_q;
        busy          = (state != IDLE);
        done          = (state == DONE);
    end

    // Index counter and beat capture register
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= FIRST_L;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= 5'd0;
            out_data_q  <= 64'd0;
        end else if (abort) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= FIRST_L;
                    end
                end
                READ: begin
                    if (halted) begin
                        out_data_q  <= bus.rf_rdata;
                        out_idx_q   <= idx;
                        out_last_q  <= (idx == LAST_L);
                        out_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        // idx stops at LAST_IDX: the last beat never advances it
                        if (!out_last_q) begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
module tb_reg_dump_ctrl;

    localparam int F = 1;
    localparam int L = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, halted, busy, done;
    logic start2, abort2, halted2, busy2, done2;

    reg_dump_ctrl_if bus ();
    reg_dump_ctrl_if bus2 ();

    logic [63:0] rf_mem [32];

    // Register file model: asynchronous read
    assign bus.rf_rdata  = rf_mem[bus.rf_addr];
    assign bus2.rf_rdata = rf_mem[bus2.rf_addr];

    reg_dump_ctrl #(.FIRST_IDX(F), .LAST_IDX(L)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .halted (halted),
        .busy   (busy),
        .done   (done),
        .bus    (bus.master)
    );

    reg_dump_ctrl #(.FIRST_IDX(5), .LAST_IDX(5)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .start  (start2),
        .abort  (abort2),
        .halted (halted2),
        .busy   (busy2),
        .done   (done2),
        .bus    (bus2.master)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete dump on the default instance. The reference keeps the list of
    // indices still owed and where the dump stands (reading / holding a beat /
    // finishing); every cycle all visible outputs are compared with it.
    task automatic run_dump(input int p_halt, input int p_ready, input int p_start,
                            input int hold_idx, input int gap_idx, input int abort_idx);
        int  q[$];
        int  phase;      // 0 idle, 1 reading, 2 beat presented, 3 finished
        int  beats;
        int  hold_n;
        int  gap_n;
        bit  aborted;
        int  cyc;
        q.delete();
        for (int i = F; i <= L; i++) q.push_back(i);
        beats = 0; hold_n = 0; gap_n = 0; aborted = 1'b0;
        abort = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        phase = 1;
        cyc = 0;
        while (phase != 0 && cyc < 2000) begin
            halted        = ($urandom_range(0, 99) < p_halt);
            bus.out_ready = ($urandom_range(0, 99) < p_ready);
            start         = ($urandom_range(0, 99) < p_start);
            abort         = 1'b0;
            if (phase == 1 && q[0] == gap_idx && gap_n < 4) begin
                halted = 1'b0;
                gap_n++;
            end
            if (phase == 2 && q[0] == hold_idx && hold_n < 5) begin
                bus.out_ready = 1'b0;
                hold_n++;
            end
            if (phase == 2 && q[0] == abort_idx) abort = 1'b1;
            #1;
            chk("busy", busy, 1'b1);
            chk("rf_sel", bus.rf_sel, (phase == 1) && halted);
            chk("rf_addr", bus.rf_addr, (phase == 1) ? q[0] : 0);
            chk("out_valid", bus.out_valid, phase == 2);
            chk("done", done, phase == 3);
            if (phase == 2) begin
                chk("out_idx", bus.out_idx, q[0]);
                chk("out_data", bus.out_data, rf_mem[q[0]]);
                chk("out_last", bus.out_last, q[0] == L);
            end
            if (abort) begin
                phase = 0;
                aborted = 1'b1;
            end else begin
                case (phase)
                    1: if (halted) phase = 2;
                    2: if (bus.out_ready) begin
                        void'(q.pop_front());
                        beats++;
                        phase = (q.size() == 0) ? 3 : 1;
                    end
                    3: phase = 0;
                    default: phase = 0;
                endcase
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("dump_timeout", phase, 0);
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", bus.out_valid, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_rf_sel", bus.rf_sel, 1'b0);
        if (aborted) begin
            chk("abort_last", bus.out_last, 1'b0);
            chk("abort_beats", beats, abort_idx - F);
        end else begin
            chk("beats", beats, L - F + 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; halted = 1'b1;
        bus.out_ready = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; halted2 = 1'b1;
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf_mem[i] = 64'(i) * 64'h11;

        // Reset values
        tick;
        tick;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_idx", bus.out_idx, 5'd0);
        chk("rst_data", bus.out_data, 64'd0);
        chk("rst_last", bus.out_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rf_sel", bus.rf_sel, 1'b0);
        rst = 1'b0;
        tick;

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        #1;
        chk("abort_vs_start", busy, 1'b0);

        // Plain full dump, then hold on idx 3 and a halted gap at idx 7
        run_dump(100, 100, 0, 0, 0, 0);
        run_dump(100, 100, 0, 3, 7, 0);
        // Abort while idx 10 is presented, then a fresh dump from the first index
        run_dump(100, 100, 0, 0, 0, 10);
        run_dump(100, 100, 0, 0, 0, 0);

        // Random register contents and random halted / out_ready / stray start
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
            run_dump(60, 60, 20, 0, 0, 0);
        end

        // Reset in the middle of a dump, with start held alongside it
        halted = 1'b1; bus.out_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1; start = 1'b1;
        tick;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_rf_sel", bus.rf_sel, 1'b0);
        chk("mrst_valid", bus.out_valid, 1'b0);
        chk("mrst_idx", bus.out_idx, 5'd0);
        chk("mrst_data", bus.out_data, 64'd0);
        chk("mrst_last", bus.out_last, 1'b0);
        chk("mrst_done", done, 1'b0);
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_idle", busy, 1'b0);
        end

        // Single-register instance
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        chk("one_busy", busy2, 1'b1);
        chk("one_rf_sel", bus2.rf_sel, 1'b1);
        chk("one_rf_addr", bus2.rf_addr, 5'd5);
        tick;
        chk("one_valid", bus2.out_valid, 1'b1);
        chk("one_idx", bus2.out_idx, 5'd5);
        chk("one_data", bus2.out_data, rf_mem[5]);
        chk("one_last", bus2.out_last, 1'b1);
        tick;
        chk("one_done", done2, 1'b1);
        chk("one_valid_clr", bus2.out_valid, 1'b0);
        tick;
        chk("one_done_end", done2, 1'b0);
        chk("one_busy_end", busy2, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
